// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions used by the iterative divider.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } div_state_t;

  localparam int DIV_CYCLES = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the divider.
interface div_unit_if
  import mips_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, q} left and try to subtract the divisor.
module div_step
  import mips_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] divisor_mag_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           borrow;

  always_comb begin
    shifted = {rem_i, q_i[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_mag_i};
    // A set top bit means shifted >= 2^WIDTH > divisor, so the subtraction always succeeds.
    borrow  = ~shifted[WIDTH] & trial[WIDTH];
    rem_o   = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    q_o     = {q_i[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: fixed 33-cycle latency, writes LO/HI.
module div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] rem_step, quo_step;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i         (rem_q),
    .q_i           (quo_q),
    .divisor_mag_i (dmag_q),
    .rem_o         (rem_step),
    .q_o           (quo_step)
  );

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dmag_d      = dmag_q;
    dividend_d  = dividend_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = RUN;
          cnt_d      = '0;
          rem_d      = '0;
          quo_d      = magnitude(bus.dividend, bus.is_signed);
          dmag_d     = magnitude(bus.divisor, bus.is_signed);
          dividend_d = bus.dividend;
          negq_d     = bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          negr_d     = bus.is_signed & bus.dividend[WIDTH-1];
          dz_d       = (bus.divisor == '0);
        end
      end
      RUN: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        // Divide-by-zero bypasses sign correction: LO all ones, HI the raw dividend.
        if (dz_q) begin
          quotient_d  = '1;
          remainder_d = dividend_q;
        end else begin
          quotient_d  = negq_q ? -quo_q : quo_q;
          remainder_d = negr_q ? -rem_q : rem_q;
        end
        dbz_d   = dz_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dmag_q      <= '0;
      dividend_q  <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dmag_q      <= dmag_d;
      dividend_q  <= dividend_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule
